// File: rtl/alu_driver.sv
// alu_driver: single-outstanding command sequencer for a 4-bit combinational ALU.
// It registers operands onto the ALU, waits a fixed settle time, then captures
// the result and flags into a response slot. The response slot supports
// backpressure. The block also keeps a capture counter and a sticky overflow flag.
module alu_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_c_out,
  input  logic       alu_of,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic [2:0] rsp_flags,
  output logic [7:0] op_count,
  output logic       sticky_of,
  input  logic       clr_sticky
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  state_t     r_state;
  state_t     w_next;
  logic       w_accept;
  logic       w_capture;
  logic [3:0] r_cnt;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [2:0] r_alu_op;
  logic [3:0] r_rsp_result;
  logic [2:0] r_rsp_flags;
  logic [7:0] r_op_count;
  logic       r_sticky_of;

  // Next-state and handshake strobes; cmd/rsp inputs only matter in their own state
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = WAIT;
        end
      end
      WAIT: begin
        // Counter is loaded with SETTLE_CYCLES and runs down to zero; sampling
        // on the edge that finds it exhausted gives SETTLE_CYCLES+1 edges of latency.
        if (r_cnt == 4'd0) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Settle counter: load on accept, run down while waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= LP_SETTLE;
    end else if (r_state == WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // ALU operand registers hold the last accepted command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else if (w_accept) begin
      r_alu_a  <= cmd_a;
      r_alu_b  <= cmd_b;
      r_alu_op <= cmd_op;
    end
  end

  // Response slot, written only on the capture edge so it is stable under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else if (w_capture) begin
      r_rsp_result <= alu_result;
      r_rsp_flags  <= {alu_of, alu_c_out, alu_zero};
    end
  end

  // Capture counter, wraps naturally at 8 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_capture) begin
      r_op_count <= r_op_count + 8'd1;
    end
  end

  // Sticky overflow: a capturing overflow beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky_of <= 1'b0;
    end else if (w_capture && alu_of) begin
      r_sticky_of <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky_of <= 1'b0;
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == RESP);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign op_count   = r_op_count;
  assign sticky_of  = r_sticky_of;

endmodule

// File: tb/tb_alu_driver.sv
// Testbench for alu_driver: two instances (settle 1 and settle 3), each with a
// 4-bit ALU model attached; directed table vectors plus multi-cycle sequences.
module tb_alu_driver;

  logic clk;
  logic rst;

  // Instance with SETTLE_CYCLES = 1
  logic       cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1, clr_sticky1, sticky1;
  logic [3:0] cmd_a1, cmd_b1, alu_a1, alu_b1, alu_result1, rsp_result1;
  logic [2:0] cmd_op1, alu_op1, rsp_flags1;
  logic       alu_zero1, alu_c_out1, alu_of1;
  logic [7:0] op_count1;

  // Instance with SETTLE_CYCLES = 3
  logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, clr_sticky3, sticky3;
  logic [3:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_result3, rsp_result3;
  logic [2:0] cmd_op3, alu_op3, rsp_flags3;
  logic       alu_zero3, alu_c_out3, alu_of3;
  logic [7:0] op_count3;

  int n_checks = 0;
  int n_err    = 0;
  int exp_cnt  = 0;
  logic exp_sticky = 1'b0;
  logic [3:0] last_a;

  // 4-bit ALU: returns {of, c_out, zero, result}; sub uses a + ~b + 1 (c_out = no borrow)
  function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic c;
    logic o;
    c = 1'b0;
    o = 1'b0;
    s = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0]; c = s[4];
        o = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r = s[3:0]; c = s[4];
        o = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = 4'd0;
    endcase
    return {o, c, (r == 4'd0), r};
  endfunction

  assign {alu_of1, alu_c_out1, alu_zero1, alu_result1} = alu_model(alu_a1, alu_b1, alu_op1);
  assign {alu_of3, alu_c_out3, alu_zero3, alu_result3} = alu_model(alu_a3, alu_b3, alu_op3);

  alu_driver #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_op(cmd_op1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
    .alu_result(alu_result1), .alu_zero(alu_zero1), .alu_c_out(alu_c_out1), .alu_of(alu_of1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_result(rsp_result1), .rsp_flags(rsp_flags1),
    .op_count(op_count1), .sticky_of(sticky1), .clr_sticky(clr_sticky1)
  );

  alu_driver #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_op(cmd_op3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_result(alu_result3), .alu_zero(alu_zero3), .alu_c_out(alu_c_out3), .alu_of(alu_of3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_result(rsp_result3), .rsp_flags(rsp_flags3),
    .op_count(op_count3), .sticky_of(sticky3), .clr_sticky(clr_sticky3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one command to dut1 and wait (bounded) for its response; leaves dut1 in RESP
  task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic clr);
    int n;
    @(negedge clk);
    check("cmd_ready_before_issue", 32'(cmd_ready1), 32'd1);
    cmd_a1 = a; cmd_b1 = b; cmd_op1 = op; cmd_valid1 = 1'b1; clr_sticky1 = clr;
    last_a = a;
    @(posedge clk);
    #1;
    cmd_valid1 = 1'b0;
    cmd_a1 = ~a; cmd_b1 = ~b; cmd_op1 = ~op;
    n = 0;
    while (!rsp_valid1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    clr_sticky1 = 1'b0;
    check("latency_s1", 32'(n), 32'd2);
    check("alu_a_held", 32'(alu_a1), 32'(a));
    check("alu_op_held", 32'(alu_op1), 32'(op));
  endtask

  // Consume the dut1 response; optionally offer a command on the same edge (must be ignored)
  task automatic release1(input logic try_cmd);
    @(negedge clk);
    rsp_ready1 = 1'b1;
    if (try_cmd) begin
      cmd_valid1 = 1'b1;
      cmd_a1 = last_a + 4'd3;
    end
    @(posedge clk);
    #1;
    rsp_ready1 = 1'b0;
    cmd_valid1 = 1'b0;
    check("cmd_ready_after_rsp", 32'(cmd_ready1), 32'd1);
    check("rsp_valid_after_rsp", 32'(rsp_valid1), 32'd0);
    check("no_accept_on_rsp_edge", 32'(alu_a1), 32'(last_a));
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] r;
    logic [2:0] f;
  } vec_t;

  vec_t vt[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vt[0] = '{a: 4'h7, b: 4'h1, op: 3'd0, r: 4'h8, f: 3'b100};
    vt[1] = '{a: 4'h3, b: 4'h3, op: 3'd1, r: 4'h0, f: 3'b011};
    vt[2] = '{a: 4'hF, b: 4'h1, op: 3'd0, r: 4'h0, f: 3'b011};
    vt[3] = '{a: 4'h8, b: 4'h1, op: 3'd1, r: 4'h7, f: 3'b110};
    vt[4] = '{a: 4'h5, b: 4'h3, op: 3'd2, r: 4'h1, f: 3'b000};
    vt[5] = '{a: 4'hA, b: 4'h5, op: 3'd3, r: 4'hF, f: 3'b000};
    vt[6] = '{a: 4'hC, b: 4'hC, op: 3'd4, r: 4'h0, f: 3'b001};
    vt[7] = '{a: 4'h2, b: 4'h5, op: 3'd1, r: 4'hD, f: 3'b000};

    rst = 1'b1;
    cmd_valid1 = 0; cmd_a1 = 0; cmd_b1 = 0; cmd_op1 = 0; rsp_ready1 = 0; clr_sticky1 = 0;
    cmd_valid3 = 0; cmd_a3 = 0; cmd_b3 = 0; cmd_op3 = 0; rsp_ready3 = 0; clr_sticky3 = 0;
    last_a = '0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready1), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("rst_op_count", 32'(op_count1), 32'd0);
    check("rst_sticky", 32'(sticky1), 32'd0);
    check("rst_alu_a", 32'(alu_a1), 32'd0);
    check("rst_rsp_result", 32'(rsp_result1), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors: first is the add-overflow case, second the zero-result sub
    for (int i = 0; i < 8; i++) begin
      issue1(vt[i].a, vt[i].b, vt[i].op, 1'b0);
      exp_cnt++;
      if (vt[i].f[2]) exp_sticky = 1'b1;
      check($sformatf("vec%0d_result", i), 32'(rsp_result1), 32'(vt[i].r));
      check($sformatf("vec%0d_flags", i), 32'(rsp_flags1), 32'(vt[i].f));
      check($sformatf("vec%0d_op_count", i), 32'(op_count1), 32'(exp_cnt));
      check($sformatf("vec%0d_sticky", i), 32'(sticky1), 32'(exp_sticky));
      release1(i[0]);
    end

    // Backpressure: response held for 5 cycles while commands are offered
    issue1(4'h1, 4'h2, 3'd0, 1'b0);
    exp_cnt++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmd_valid1 = 1'b1; cmd_a1 = 4'h9; cmd_b1 = 4'h9;
      @(posedge clk);
      #1;
      cmd_valid1 = 1'b0;
      check("bp_rsp_valid", 32'(rsp_valid1), 32'd1);
      check("bp_rsp_result", 32'(rsp_result1), 32'h3);
      check("bp_rsp_flags", 32'(rsp_flags1), 32'h0);
      check("bp_cmd_ready", 32'(cmd_ready1), 32'd0);
      check("bp_alu_a", 32'(alu_a1), 32'h1);
      check("bp_op_count", 32'(op_count1), 32'(exp_cnt));
    end
    release1(1'b1);

    // Sticky race: clear first, then capture an overflow while clr_sticky is held
    @(negedge clk);
    clr_sticky1 = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky1 = 1'b0;
    check("sticky_cleared", 32'(sticky1), 32'd0);
    issue1(4'h7, 4'h1, 3'd0, 1'b1);
    exp_cnt++;
    check("sticky_set_wins", 32'(sticky1), 32'd1);
    @(negedge clk);
    clr_sticky1 = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky1 = 1'b0;
    check("sticky_clear_alone", 32'(sticky1), 32'd0);
    check("op_count_race", 32'(op_count1), 32'(exp_cnt));
    release1(1'b0);

    // Reset during WAIT discards the op and zeroes everything at once
    @(negedge clk);
    cmd_a1 = 4'h5; cmd_b1 = 4'h6; cmd_op1 = 3'd0; cmd_valid1 = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid1 = 1'b0;
    check("pre_rst_in_wait", 32'(cmd_ready1), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready1), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("mid_rst_alu", 32'({alu_a1, alu_b1, alu_op1}), 32'd0);
    check("mid_rst_rsp", 32'({rsp_result1, rsp_flags1}), 32'd0);
    check("mid_rst_op_count", 32'(op_count1), 32'd0);
    check("mid_rst_sticky", 32'(sticky1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_rsp", 32'(rsp_valid1), 32'd0);
    end
    exp_cnt = 0;
    exp_sticky = 1'b0;
    issue1(4'h5, 4'h6, 3'd0, 1'b0);
    exp_cnt++;
    check("post_rst_result", 32'(rsp_result1), 32'hB);
    check("post_rst_flags", 32'(rsp_flags1), 32'b100);
    check("post_rst_op_count", 32'(op_count1), 32'(exp_cnt));
    release1(1'b0);

    // SETTLE_CYCLES=3: 256 back-to-back ops, latency 4 each, counter wraps to 0
    @(negedge clk);
    check("s3_start_idle", 32'(cmd_ready3), 32'd1);
    check("s3_start_count", 32'(op_count3), 32'd0);
    cmd_valid3 = 1'b1; rsp_ready3 = 1'b1; cmd_b3 = 4'h1; cmd_op3 = 3'd0;
    for (int i = 0; i < 256; i++) begin
      cmd_a3 = i[3:0];
      @(posedge clk);
      #1;
      n = 0;
      while (!rsp_valid3 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("s3_latency", 32'(n), 32'd4);
      check("s3_result", 32'(rsp_result3), 32'((i + 1) & 15));
      @(posedge clk);
      #1;
      check("s3_idle_after_rsp", 32'(cmd_ready3), 32'd1);
    end
    cmd_valid3 = 1'b0;
    check("s3_op_count_wrap", 32'(op_count3), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
